// File: rtl/gen_fip_pkg.sv
// Shared definitions for the signed fixed-point arithmetic blocks: accumulator
// FSM states and width helpers for integer/fraction growth.
package gen_fip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } fip_acc_state_t;

    // Extra integer bits needed so a sum of max_terms operands never overflows.
    function automatic int fip_guard_w(input int max_terms);
        return $clog2(max_terms);
    endfunction

    // Width of a counter that can hold 0..max_terms.
    function automatic int fip_cnt_w(input int max_terms);
        return $clog2(max_terms + 1);
    endfunction

    // Exact accumulator width for max_terms operands of int_w.fract_w format.
    function automatic int fip_acc_w(input int int_w, input int fract_w, input int max_terms);
        return int_w + fip_guard_w(max_terms) + fract_w;
    endfunction

endpackage

// File: rtl/gen_fip_sign_round_sat.sv
// Combinational signed fixed-point format conversion: pad, round half-up or
// truncate the fraction, then saturate or wrap the integer part. ovf_o flags
// any value (including a rounding carry) that does not fit the output format.
module gen_fip_sign_round_sat
    import gen_fip_pkg::*;
#(
    parameter int IN_INT_W    = 3,
    parameter int IN_FRACT_W  = 5,
    parameter int OUT_INT_W   = 3,
    parameter int OUT_FRACT_W = 5,
    parameter bit SAT_EN      = 1'b1,
    parameter bit ROUND_EN    = 1'b1
) (
    input  logic [IN_INT_W+IN_FRACT_W-1:0]   num_i,
    output logic [OUT_INT_W+OUT_FRACT_W-1:0] res_o,
    output logic                             ovf_o
);

    localparam int IN_W      = IN_INT_W + IN_FRACT_W;
    // One spare integer bit so a rounding carry is never lost before the range check.
    localparam int MID_INT_W = IN_INT_W + 1;
    localparam int MID_W     = MID_INT_W + OUT_FRACT_W;
    localparam int OUT_W     = OUT_INT_W + OUT_FRACT_W;

    logic signed [IN_W-1:0]  num_s;
    logic signed [MID_W-1:0] mid;

    assign num_s = num_i;

    generate
        if (OUT_FRACT_W >= IN_FRACT_W) begin : g_frac_pad
            assign mid = MID_W'(num_s) <<< (OUT_FRACT_W - IN_FRACT_W);
        end else begin : g_frac_drop
            localparam int DROP_W = IN_FRACT_W - OUT_FRACT_W;
            localparam int EXT_W  = IN_W + 1;
            // Half an output LSB when rounding; truncation is an arithmetic shift (toward -inf).
            localparam logic signed [EXT_W-1:0] HALF =
                ROUND_EN ? (EXT_W'(1) <<< (DROP_W - 1)) : '0;
            logic signed [EXT_W-1:0] ext;
            assign ext = EXT_W'(num_s) + HALF;
            assign mid = MID_W'(ext >>> DROP_W);
        end

        if (OUT_INT_W >= MID_INT_W) begin : g_int_widen
            assign res_o = OUT_W'(mid);
            assign ovf_o = 1'b0;
        end else begin : g_int_narrow
            // Discarded integer bits plus the new sign bit must all agree.
            localparam int TOP_W = MID_W - OUT_W + 1;
            localparam logic [OUT_W-1:0] MIN_NEG = OUT_W'(1) << (OUT_W - 1);
            localparam logic [OUT_W-1:0] MAX_POS = ~MIN_NEG;
            logic [TOP_W-1:0] top;
            logic             fits;
            assign top  = mid[MID_W-1:OUT_W-1];
            assign fits = (&top) | ~(|top);

            // Keep the low bits, or clamp to the extreme matching the true sign.
            always_comb begin
                // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
                res_o = mid[OUT_W-1:0];
                ovf_o = 1'b0;
                if (!fits) begin
                    ovf_o = 1'b1;
                    if (SAT_EN) begin
                        res_o = mid[MID_W-1] ? MIN_NEG : MAX_POS;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/gen_fip_sign_accumulator.sv
// Sequential signed fixed-point accumulator: sums a run of operands exactly,
// then converts the sum to the result format and reports overflow with a
// one-cycle done pulse.
module gen_fip_sign_accumulator
    import gen_fip_pkg::*;
#(
    parameter int IN_INT_W    = 1,
    parameter int IN_FRACT_W  = 5,
    parameter int MAX_TERMS   = 4,
    parameter int RES_INT_W   = IN_INT_W + fip_guard_w(MAX_TERMS),
    parameter int RES_FRACT_W = IN_FRACT_W,
    parameter bit SAT_EN      = 1'b1,
    parameter bit ROUND_EN    = 1'b1
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                i_start_pls,
    input  logic [fip_cnt_w(MAX_TERMS)-1:0]     i_num_terms,
    input  logic                                i_valid,
    input  logic [IN_INT_W+IN_FRACT_W-1:0]      i_num,
    output logic                                o_busy,
    output logic                                o_done_pls,
    output logic [RES_INT_W+RES_FRACT_W-1:0]    o_res,
    output logic                                o_ovf
);

    localparam int GUARD_W = fip_guard_w(MAX_TERMS);
    localparam int CNT_W   = fip_cnt_w(MAX_TERMS);
    localparam int ACC_W   = fip_acc_w(IN_INT_W, IN_FRACT_W, MAX_TERMS);
    localparam int RES_W   = RES_INT_W + RES_FRACT_W;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

    fip_acc_state_t          state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [RES_W-1:0]        res_q;
    logic [RES_W-1:0]        res_d;
    logic                    ovf_q;
    logic                    ovf_d;
    logic                    busy_q;
    logic                    done_q;
    logic [CNT_W-1:0]        terms_clamped;
    logic signed [ACC_W-1:0] num_ext;

    assign terms_clamped = (i_num_terms > MAX_CNT) ? MAX_CNT : i_num_terms;
    assign num_ext       = ACC_W'(signed'(i_num));

    gen_fip_sign_round_sat #(
        .IN_INT_W    (IN_INT_W + GUARD_W),
        .IN_FRACT_W  (IN_FRACT_W),
        .OUT_INT_W   (RES_INT_W),
        .OUT_FRACT_W (RES_FRACT_W),
        .SAT_EN      (SAT_EN),
        .ROUND_EN    (ROUND_EN)
    ) u_round_sat (
        .num_i (acc_q),
        .res_o (res_d),
        .ovf_o (ovf_d)
    );

    // Run control: start/abort, operand accumulation, and registered result hand-off.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (i_start_pls) begin
                        acc_q   <= '0;
                        cnt_q   <= terms_clamped;
                        busy_q  <= 1'b1;
                        state_q <= (terms_clamped == '0) ? OUT : ACCUM;
                    end
                end
                ACCUM: begin
                    if (i_start_pls) begin
                        // Abort: the old run is discarded without a done pulse.
                        acc_q   <= '0;
                        cnt_q   <= terms_clamped;
                        state_q <= (terms_clamped == '0) ? OUT : ACCUM;
                    end else if (i_valid) begin
                        acc_q <= acc_q + num_ext;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= OUT;
                        end
                    end
                end
                OUT: begin
                    res_q   <= res_d;
                    ovf_q   <= ovf_d;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_done_pls = done_q;
    assign o_res      = res_q;
    assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_gen_fip_sign_accumulator.sv
// Directed bench for gen_fip_sign_accumulator. Five instances share one stimulus
// stream and differ only in result format: default Q3.5, Q1.5 saturating,
// Q1.5 wrapping, Q3.3 rounding and Q3.3 truncating.
module tb_gen_fip_sign_accumulator;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [2:0] nterms;
    logic       valid;
    logic [5:0] num;

    logic [7:0] res_def;
    logic [5:0] res_sat, res_wrap, res_rnd, res_trn;
    logic       ovf_def, ovf_sat, ovf_wrap, ovf_rnd, ovf_trn;
    logic       busy_def, busy_sat, busy_wrap, busy_rnd, busy_trn;
    logic       done_def, done_sat, done_wrap, done_rnd, done_trn;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    // Counts every done pulse, to detect pulses from aborted or reset runs.
    always @(posedge clk) begin
        if (done_def === 1'b1) done_cnt++;
    end

    gen_fip_sign_accumulator u_def (
        .clk(clk), .rstn(rstn), .i_start_pls(start), .i_num_terms(nterms),
        .i_valid(valid), .i_num(num), .o_busy(busy_def), .o_done_pls(done_def),
        .o_res(res_def), .o_ovf(ovf_def)
    );

    gen_fip_sign_accumulator #(.RES_INT_W(1), .SAT_EN(1'b1)) u_sat (
        .clk(clk), .rstn(rstn), .i_start_pls(start), .i_num_terms(nterms),
        .i_valid(valid), .i_num(num), .o_busy(busy_sat), .o_done_pls(done_sat),
        .o_res(res_sat), .o_ovf(ovf_sat)
    );

    gen_fip_sign_accumulator #(.RES_INT_W(1), .SAT_EN(1'b0)) u_wrap (
        .clk(clk), .rstn(rstn), .i_start_pls(start), .i_num_terms(nterms),
        .i_valid(valid), .i_num(num), .o_busy(busy_wrap), .o_done_pls(done_wrap),
        .o_res(res_wrap), .o_ovf(ovf_wrap)
    );

    gen_fip_sign_accumulator #(.RES_FRACT_W(3), .ROUND_EN(1'b1)) u_rnd (
        .clk(clk), .rstn(rstn), .i_start_pls(start), .i_num_terms(nterms),
        .i_valid(valid), .i_num(num), .o_busy(busy_rnd), .o_done_pls(done_rnd),
        .o_res(res_rnd), .o_ovf(ovf_rnd)
    );

    gen_fip_sign_accumulator #(.RES_FRACT_W(3), .ROUND_EN(1'b0)) u_trn (
        .clk(clk), .rstn(rstn), .i_start_pls(start), .i_num_terms(nterms),
        .i_valid(valid), .i_num(num), .o_busy(busy_trn), .o_done_pls(done_trn),
        .o_res(res_trn), .o_ovf(ovf_trn)
    );

    typedef struct {
        logic [2:0]      n;      // value driven on i_num_terms
        int              nops;   // operands actually fed (after clamping)
        logic [3:0][5:0] ops;
        logic [7:0]      e_def;
        logic [5:0]      e_sat;
        logic [5:0]      e_wrap;
        logic [5:0]      e_rnd;
        logic [5:0]      e_trn;
        logic [4:0]      e_ovf;  // {def, sat, wrap, rnd, trn}
    } vec_t;

    vec_t vecs[10];
    vec_t v_restart;

    function automatic vec_t mk(input logic [2:0] n, input int nops,
                                input logic [5:0] o0, input logic [5:0] o1,
                                input logic [5:0] o2, input logic [5:0] o3,
                                input logic [7:0] e_def, input logic [5:0] e_sat,
                                input logic [5:0] e_wrap, input logic [5:0] e_rnd,
                                input logic [5:0] e_trn, input logic [4:0] e_ovf);
        vec_t v;
        v.n      = n;
        v.nops   = nops;
        v.ops[0] = o0;
        v.ops[1] = o1;
        v.ops[2] = o2;
        v.ops[3] = o3;
        v.e_def  = e_def;
        v.e_sat  = e_sat;
        v.e_wrap = e_wrap;
        v.e_rnd  = e_rnd;
        v.e_trn  = e_trn;
        v.e_ovf  = e_ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, " done_all"}, {done_def, done_sat, done_wrap, done_rnd, done_trn}, 5'h1F);
        check({tag, " busy_in_done"}, busy_def, 1'b1);
        check({tag, " res_def"},  res_def,  v.e_def);
        check({tag, " res_sat"},  res_sat,  v.e_sat);
        check({tag, " res_wrap"}, res_wrap, v.e_wrap);
        check({tag, " res_rnd"},  res_rnd,  v.e_rnd);
        check({tag, " res_trn"},  res_trn,  v.e_trn);
        check({tag, " ovf"}, {ovf_def, ovf_sat, ovf_wrap, ovf_rnd, ovf_trn}, v.e_ovf);
    endtask

    // Waits (bounded) for the done pulse; returns edges waited after the last accepted input.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done_def !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
    endtask

    // Full run: start pulse, operands with optional stall cycles, result and hold checks.
    task automatic run_vec(input vec_t v, input int stall, input string tag);
        int lat;
        start  = 1'b1;
        nterms = v.n;
        tick();
        start  = 1'b0;
        check({tag, " busy_after_start"}, busy_def, 1'b1);
        for (int i = 0; i < v.nops; i++) begin
            if (i > 0) begin
                for (int s = 0; s < stall; s++) begin
                    num = 6'h2A;
                    tick();
                end
            end
            valid = 1'b1;
            num   = v.ops[i];
            tick();
            valid = 1'b0;
            num   = 6'h15;
        end
        wait_done(lat);
        check({tag, " latency"}, lat, 1);
        check_result(tag, v);
        tick();
        check({tag, " done_low"}, done_def, 1'b0);
        check({tag, " busy_low"}, busy_def, 1'b0);
        check({tag, " res_hold"}, res_def, v.e_def);
    endtask

    initial begin
        int lat;
        int cnt0;

        //           n     nops ops (Q1.5)                            def    sat    wrap   rnd    trn    ovf
        vecs[0] = mk(3'd3, 3, 6'h10, 6'h08, 6'h3C, 6'h00, 8'h14, 6'h14, 6'h14, 6'h05, 6'h05, 5'b00000);
        vecs[1] = mk(3'd4, 4, 6'h1F, 6'h1F, 6'h1F, 6'h1F, 8'h7C, 6'h1F, 6'h3C, 6'h1F, 6'h1F, 5'b01100);
        vecs[2] = mk(3'd1, 1, 6'h03, 6'h00, 6'h00, 6'h00, 8'h03, 6'h03, 6'h03, 6'h01, 6'h00, 5'b00000);
        vecs[3] = mk(3'd0, 0, 6'h00, 6'h00, 6'h00, 6'h00, 8'h00, 6'h00, 6'h00, 6'h00, 6'h00, 5'b00000);
        vecs[4] = mk(3'd7, 4, 6'h20, 6'h20, 6'h20, 6'h20, 8'h80, 6'h20, 6'h00, 6'h20, 6'h20, 5'b01100);
        vecs[5] = mk(3'd4, 4, 6'h1F, 6'h1F, 6'h1F, 6'h1E, 8'h7B, 6'h1F, 6'h3B, 6'h1F, 6'h1E, 5'b01100);
        vecs[6] = mk(3'd2, 2, 6'h3F, 6'h3E, 6'h00, 6'h00, 8'hFD, 6'h3D, 6'h3D, 6'h3F, 6'h3F, 5'b00000);
        vecs[7] = mk(3'd2, 2, 6'h01, 6'h3D, 6'h00, 6'h00, 8'hFE, 6'h3E, 6'h3E, 6'h00, 6'h3F, 5'b00000);
        vecs[8] = mk(3'd2, 2, 6'h1F, 6'h01, 6'h00, 6'h00, 8'h20, 6'h1F, 6'h20, 6'h08, 6'h08, 5'b01100);
        vecs[9] = mk(3'd2, 2, 6'h30, 6'h30, 6'h00, 6'h00, 8'hE0, 6'h20, 6'h20, 6'h38, 6'h38, 5'b00000);
        // Restarted run: 0.25 + 0.125 = 0.375.
        v_restart = mk(3'd2, 2, 6'h08, 6'h04, 6'h00, 6'h00, 8'h0C, 6'h0C, 6'h0C, 6'h03, 6'h03, 5'b00000);

        rstn   = 1'b0;
        start  = 1'b0;
        nterms = 3'd0;
        valid  = 1'b0;
        num    = 6'h00;
        tick();
        tick();
        check("reset res", {res_def, res_sat, res_wrap, res_rnd, res_trn}, 32'h0);
        check("reset ovf", {ovf_def, ovf_sat, ovf_wrap, ovf_rnd, ovf_trn}, 5'h0);
        check("reset busy", {busy_def, busy_sat, busy_wrap, busy_rnd, busy_trn}, 5'h0);
        check("reset done", {done_def, done_sat, done_wrap, done_rnd, done_trn}, 5'h0);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // i_valid in IDLE is ignored, then stalls between operands leave the sum unchanged.
        valid = 1'b1;
        num   = 6'h1F;
        tick();
        tick();
        valid = 1'b0;
        check("idle_valid busy", busy_def, 1'b0);
        run_vec(vecs[0], 2, "stall");

        // Restart after 2 of 3 operands: only the new run's sum and one done pulse.
        cnt0   = done_cnt;
        start  = 1'b1;
        nterms = 3'd3;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid = 1'b1;
            num   = 6'h10;
            tick();
        end
        valid = 1'b0;
        run_vec(v_restart, 0, "restart");
        check("restart done_count", done_cnt - cnt0, 1);

        // Back-to-back: a start in the done cycle is accepted.
        cnt0   = done_cnt;
        start  = 1'b1;
        nterms = 3'd1;
        tick();
        start  = 1'b0;
        valid  = 1'b1;
        num    = 6'h03;
        tick();
        valid  = 1'b0;
        wait_done(lat);
        check("b2b first latency", lat, 1);
        check("b2b first res", res_def, 8'h03);
        start  = 1'b1;
        nterms = 3'd1;
        tick();
        start  = 1'b0;
        check("b2b busy_restart", busy_def, 1'b1);
        valid  = 1'b1;
        num    = 6'h10;
        tick();
        valid  = 1'b0;
        wait_done(lat);
        check("b2b second latency", lat, 1);
        check("b2b second res", res_def, 8'h10);
        tick();
        check("b2b done_count", done_cnt - cnt0, 2);

        // Reset mid-ACCUM: outputs cleared, no done pulse, next run is correct.
        cnt0   = done_cnt;
        start  = 1'b1;
        nterms = 3'd3;
        tick();
        start  = 1'b0;
        valid  = 1'b1;
        num    = 6'h10;
        tick();
        valid  = 1'b0;
        rstn   = 1'b0;
        tick();
        rstn   = 1'b1;
        check("midreset res", {res_def, res_sat, res_wrap, res_rnd, res_trn}, 32'h0);
        check("midreset ovf", {ovf_def, ovf_sat, ovf_wrap, ovf_rnd, ovf_trn}, 5'h0);
        check("midreset busy", busy_def, 1'b0);
        valid = 1'b1;
        num   = 6'h1F;
        tick();
        tick();
        tick();
        valid = 1'b0;
        check("midreset no_done", done_cnt - cnt0, 0);
        check("midreset busy_idle", busy_def, 1'b0);
        run_vec(vecs[0], 0, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
